// File: rtl/btn_ctrl.sv
// Button control stage for the stopwatch: synchronises and debounces the
// start/stop and clear buttons, runs the IDLE/RUN/PAUSE state machine and
// produces the gated one-second tick and the one-cycle clear pulse.
module btn_ctrl #(
  parameter int TICK_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk_btn,
  input  logic       rst_btn,
  input  logic       btn_ss_in,
  input  logic       btn_clr_in,
  output logic       run_out,
  output logic [1:0] state_out,
  output logic       sec_tick_out,
  output logic       clear_out
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  // Bit positions of the two buttons in the per-button vectors below.
  localparam int BTN_SS  = 0;
  localparam int BTN_CLR = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  logic [1:0]      raw;
  logic [1:0]      meta;
  logic [1:0]      sync;
  logic [1:0]      stable;
  logic [1:0]      stable_d;
  logic [1:0]      press;
  logic [DB_W-1:0] db_cnt [2];

  state_e          state;
  state_e          state_next;
  logic            clear_next;

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;

  assign raw = {btn_clr_in, btn_ss_in};

  // Two-flop synchronisers bring both raw buttons into the clk_btn domain.
  always_ff @(posedge clk_btn or posedge rst_btn) begin
    if (rst_btn) begin
      meta <= '0;
      sync <= '0;
    end else begin
      // NOTE: non-blocking assignments make sync take the old meta, so this is a real two-stage chain.
      meta <= raw;
      sync <= meta;
    end
  end

  // Debounce each button, then register a one-cycle pulse on each debounced rise.
  always_ff @(posedge clk_btn or posedge rst_btn) begin
    if (rst_btn) begin
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      // NOTE: this two-entry counter array is plain flops, not RAM, so it is reset like any other register.
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Next state and clear decision from this cycle's press pulses.
  always_comb begin
    // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
    state_next = state;
    clear_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (press[BTN_CLR]) begin
          clear_next = 1'b1;
        end else if (press[BTN_SS]) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // A clear while running is ignored; start/stop wins a simultaneous press.
        if (press[BTN_SS]) begin
          state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press[BTN_CLR]) begin
          state_next = S_IDLE;
          clear_next = 1'b1;
        end else if (press[BTN_SS]) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register and the clear pulse, which lines up with the first cycle of the new state.
  always_ff @(posedge clk_btn or posedge rst_btn) begin
    if (rst_btn) begin
      state     <= S_IDLE;
      clear_out <= 1'b0;
    end else begin
      state     <= state_next;
      clear_out <= clear_next;
    end
  end

  // The divider only counts RUN cycles; clear only happens outside RUN, so tick and clear never overlap.
  assign div_wrap = (state == S_RUN) && (div_cnt == DIV_LAST);

  // Second divider: counts in RUN, holds in PAUSE, zeroed on every clear.
  always_ff @(posedge clk_btn or posedge rst_btn) begin
    if (rst_btn) begin
      div_cnt      <= '0;
      sec_tick_out <= 1'b0;
    end else begin
      sec_tick_out <= div_wrap;
      if (clear_next || div_wrap) begin
        div_cnt <= '0;
      end else if (state == S_RUN) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  assign state_out = state;
  assign run_out   = (state == S_RUN);

endmodule

// File: tb/tb_btn_ctrl.sv
// Bench for btn_ctrl: directed and random button stimulus, a behavioural
// model that predicts state changes, clear pulses and ticks by cycle, and a
// separate monitor that compares what the design presents with the prediction.
module tb_btn_ctrl;

  localparam int DB = 4;
  localparam int TD = 10;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;

  logic       clk_btn    = 1'b0;
  logic       rst_btn    = 1'b1;
  logic       btn_ss_in  = 1'b0;
  logic       btn_clr_in = 1'b0;
  logic       run_out;
  logic [1:0] state_out;
  logic       sec_tick_out;
  logic       clear_out;

  btn_ctrl #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk_btn     (clk_btn),
    .rst_btn     (rst_btn),
    .btn_ss_in   (btn_ss_in),
    .btn_clr_in  (btn_clr_in),
    .run_out     (run_out),
    .state_out   (state_out),
    .sec_tick_out(sec_tick_out),
    .clear_out   (clear_out)
  );

  always #5 clk_btn = ~clk_btn;

  typedef enum int {EV_STATE = 0, EV_CLEAR = 1, EV_TICK = 2} ev_kind_e;
  typedef struct {
    int       cyc;
    ev_kind_e kind;
    int       val;
  } ev_t;

  ev_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;

  // Reference model state: button history, debounced levels, and elapsed RUN time.
  int   m_state;
  int   m_run_total;
  logic m_h1 [2];
  logic m_h2 [2];
  logic m_stable [2];
  int   m_disagree [2];
  int   m_fire [2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic void expect_ev(input ev_kind_e k, input int v);
    ev_t e;
    e.cyc  = cyc;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Model: a button level counts once the synchronised input disagreed with it
  // for DB samples in a row; its rise acts on the FSM two edges later. Ticks
  // fall on every multiple of TD RUN cycles accumulated since the last clear.
  always @(posedge clk_btn) begin
    cyc++;
    if (rst_btn) begin
      m_state     = ST_IDLE;
      m_run_total = 0;
      for (int b = 0; b < 2; b++) begin
        m_h1[b]       = 1'b0;
        m_h2[b]       = 1'b0;
        m_stable[b]   = 1'b0;
        m_disagree[b] = 0;
        m_fire[b]     = -1;
      end
    end else begin
      bit   ss_p;
      bit   clr_p;
      bit   clr_acc;
      bit   tick;
      int   nxt;
      logic sample;
      logic raw_now [2];
      raw_now[0] = btn_ss_in;
      raw_now[1] = btn_clr_in;
      ss_p    = (m_fire[0] == cyc);
      clr_p   = (m_fire[1] == cyc);
      nxt     = m_state;
      clr_acc = 1'b0;
      tick    = 1'b0;
      if (m_state == ST_RUN) begin
        if (ss_p) nxt = ST_PAUSE;
      end else if (clr_p) begin
        nxt     = ST_IDLE;
        clr_acc = 1'b1;
      end else if (ss_p) begin
        nxt = ST_RUN;
      end
      if (m_state == ST_RUN) begin
        m_run_total++;
        if (m_run_total % TD == 0) tick = 1'b1;
      end
      if (clr_acc) m_run_total = 0;
      if (nxt != m_state) expect_ev(EV_STATE, nxt);
      if (clr_acc) expect_ev(EV_CLEAR, 1);
      if (tick) expect_ev(EV_TICK, 1);
      m_state = nxt;
      for (int b = 0; b < 2; b++) begin
        sample  = m_h2[b];
        m_h2[b] = m_h1[b];
        m_h1[b] = raw_now[b];
        if (sample != m_stable[b]) begin
          m_disagree[b]++;
          if (m_disagree[b] == DB) begin
            m_stable[b]   = sample;
            m_disagree[b] = 0;
            if (sample) m_fire[b] = cyc + 2;
          end
        end else begin
          m_disagree[b] = 0;
        end
      end
    end
  end

  task automatic observe(input ev_kind_e k, input int v);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d value %0d at cycle %0d, required no event", k, v, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_cycle", cyc, e.cyc);
      check("event_kind", k, e.kind);
      check("event_value", v, e.val);
    end
  endtask

  // Monitor: turns output activity into events and scores it against the model's queue.
  logic [1:0] prev_state = 2'd0;
  ev_t        miss_e;
  always @(negedge clk_btn) begin
    if (rst_btn) begin
      prev_state = 2'd0;
    end else begin
      check("state_level", state_out, m_state);
      check("run_level", run_out, (m_state == ST_RUN));
      check("tick_clear_exclusive", sec_tick_out & clear_out, 0);
      if (state_out != prev_state) observe(EV_STATE, state_out);
      prev_state = state_out;
      if (clear_out) observe(EV_CLEAR, 1);
      if (sec_tick_out) observe(EV_TICK, 1);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        miss_e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_event: got nothing at cycle %0d, required kind %0d value %0d", miss_e.cyc, miss_e.kind, miss_e.val);
      end
    end
  end

  task automatic drive(input logic ss, input logic clr, input int n);
    repeat (n) begin
      @(negedge clk_btn);
      btn_ss_in  = ss;
      btn_clr_in = clr;
    end
  endtask

  task automatic reset_pulse(input int hold);
    @(negedge clk_btn);
    #2;
    rst_btn = 1'b1;
    #1;
    check("reset_run_out", run_out, 0);
    check("reset_state_out", state_out, 0);
    check("reset_tick", sec_tick_out, 0);
    check("reset_clear", clear_out, 0);
    repeat (hold) @(negedge clk_btn);
    rst_btn = 1'b0;
  endtask

  task automatic random_phase(input int n);
    int ss_left;
    int clr_left;
    ss_left  = 0;
    clr_left = 0;
    repeat (n) begin
      @(negedge clk_btn);
      if (ss_left == 0) begin
        btn_ss_in = 1'($urandom_range(0, 1));
        ss_left   = int'($urandom_range(1, 12));
      end
      if (clr_left == 0) begin
        btn_clr_in = 1'($urandom_range(0, 1));
        clr_left   = int'($urandom_range(1, 12));
      end
      ss_left--;
      clr_left--;
    end
  endtask

  initial begin
    // Start/stop held through reset release: seen only after a full debounce.
    btn_ss_in = 1'b1;
    @(negedge clk_btn);
    check("init_state_out", state_out, 0);
    check("init_run_out", run_out, 0);
    check("init_tick", sec_tick_out, 0);
    check("init_clear", clear_out, 0);
    repeat (2) @(negedge clk_btn);
    rst_btn = 1'b0;
    drive(1'b1, 1'b0, 12);
    drive(1'b0, 1'b0, 25);

    // Reset while running.
    reset_pulse(2);
    drive(1'b0, 1'b0, 6);

    // Bounce rejection followed by a steady press, then a long run.
    repeat (5) begin
      drive(1'b1, 1'b0, 3);
      drive(1'b0, 1'b0, 1);
    end
    drive(1'b1, 1'b0, 10);
    drive(1'b0, 1'b0, 45);

    // Pause, hold, resume with the partial second kept.
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 20);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 20);

    // Clear in RUN is ignored; clear in PAUSE returns to IDLE and zeroes the divider.
    drive(1'b0, 1'b1, 6);
    drive(1'b0, 1'b0, 12);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 10);
    drive(1'b0, 1'b1, 6);
    drive(1'b0, 1'b0, 10);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 25);

    // Simultaneous presses: in RUN start/stop wins, in PAUSE clear wins.
    drive(1'b1, 1'b1, 6);
    drive(1'b0, 1'b0, 12);
    drive(1'b1, 1'b1, 6);
    drive(1'b0, 1'b0, 12);

    // Random button activity with resets in between.
    for (int seg = 0; seg < 3; seg++) begin
      random_phase(400);
      reset_pulse(3);
    end
    random_phase(400);

    drive(1'b0, 1'b0, 20);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
